// File: rtl/venda_pkg.sv
// Shared definitions for the vending sale sequencer: state encoding and LCD codes.
package venda_pkg;

    localparam int MAX_GIRO_PADRAO = 9;

    localparam logic [2:0] LCD_IDLE         = 3'd0;
    localparam logic [2:0] LCD_ACIONA       = 3'd1;
    localparam logic [2:0] LCD_ESPERA_QUEDA = 3'd2;
    localparam logic [2:0] LCD_CONCLUIDO    = 3'd3;
    localparam logic [2:0] LCD_ERRO         = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE         = LCD_IDLE,
        ST_ACIONA       = LCD_ACIONA,
        ST_ESPERA_QUEDA = LCD_ESPERA_QUEDA,
        ST_CONCLUIDO    = LCD_CONCLUIDO,
        ST_ERRO         = LCD_ERRO
    } estado_t;

endpackage

// File: rtl/filtro_sensor.sv
// Sensor conditioning: 2-FF synchronizer, debounce and rising-edge pulse.
module filtro_sensor #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clock_in,
    input  logic reset_in,
    input  logic sensor_in,
    output logic subida_out
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_FIM = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cont_q, cont_d;
    logic          filt_q, filt_d;
    logic          filt_ant_q, filt_ant_d;

    always_comb begin
        sync_d     = {sync_q[0], sensor_in};
        cont_d     = '0;
        filt_d     = filt_q;
        filt_ant_d = filt_q;
        // any cycle where the input agrees with the filtered value restarts the count
        if (sync_q[1] != filt_q) begin
            if (cont_q == CNT_FIM) begin
                filt_d = sync_q[1];
            end else begin
                cont_d = cont_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            sync_q     <= '0;
            cont_q     <= '0;
            filt_q     <= 1'b0;
            filt_ant_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            cont_q     <= cont_d;
            filt_q     <= filt_d;
            filt_ant_q <= filt_ant_d;
        end
    end

    assign subida_out = filt_q & ~filt_ant_q;

endmodule

// File: rtl/controle_venda.sv
// Sale sequencer: drives the relay for the requested turns, then waits for the product drop.
module controle_venda
    import venda_pkg::*;
#(
    parameter int TIMEOUT_CYCLES  = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int MAX_GIRO        = MAX_GIRO_PADRAO
) (
    input  logic       clock_in,
    input  logic       reset_in,
    input  logic       pedido_valid_in,
    input  logic [3:0] pedido_giro_in,
    output logic       pedido_ready_out,
    input  logic       sensor1_in,
    input  logic       sensor2_in,
    input  logic       ack_erro_in,
    output logic       rele_out,
    output logic [3:0] contador_giro_out,
    output logic [2:0] estado_out,
    output logic       concluido_out,
    output logic       erro_out
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_FIM = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    GIRO_MAX  = 4'(MAX_GIRO);

    estado_t       estado_q, estado_d;
    logic [3:0]    cont_q, cont_d;
    logic [3:0]    alvo_q, alvo_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          rele_q, rele_d;
    logic          s1_subida, s2_subida;

    filtro_sensor #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filtro_s1 (
        .clock_in   (clock_in),
        .reset_in   (reset_in),
        .sensor_in  (sensor1_in),
        .subida_out (s1_subida)
    );

    filtro_sensor #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filtro_s2 (
        .clock_in   (clock_in),
        .reset_in   (reset_in),
        .sensor_in  (sensor2_in),
        .subida_out (s2_subida)
    );

    always_comb begin
        estado_d = estado_q;
        cont_d   = cont_q;
        alvo_d   = alvo_q;
        timer_d  = timer_q;
        unique case (estado_q)
            ST_IDLE: begin
                if (pedido_valid_in && pedido_giro_in != 4'd0 && pedido_giro_in <= GIRO_MAX) begin
                    alvo_d   = pedido_giro_in;
                    cont_d   = 4'd0;
                    timer_d  = '0;
                    estado_d = ST_ACIONA;
                end
            end
            ST_ACIONA: begin
                // a sensor edge takes priority over a simultaneous timeout
                if (s1_subida) begin
                    cont_d  = cont_q + 4'd1;
                    timer_d = '0;
                    if (cont_q + 4'd1 == alvo_q) estado_d = ST_ESPERA_QUEDA;
                end else if (timer_q == TIMER_FIM) begin
                    estado_d = ST_ERRO;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_ESPERA_QUEDA: begin
                if (s2_subida) begin
                    estado_d = ST_CONCLUIDO;
                end else if (timer_q == TIMER_FIM) begin
                    estado_d = ST_ERRO;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_CONCLUIDO: estado_d = ST_IDLE;
            ST_ERRO: begin
                if (ack_erro_in) estado_d = ST_IDLE;
            end
            default: estado_d = ST_IDLE;
        endcase
        rele_d = (estado_d == ST_ACIONA);
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            estado_q <= ST_IDLE;
            cont_q   <= 4'd0;
            alvo_q   <= 4'd0;
            timer_q  <= '0;
            rele_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cont_q   <= cont_d;
            alvo_q   <= alvo_d;
            timer_q  <= timer_d;
            rele_q   <= rele_d;
        end
    end

    assign rele_out          = rele_q;
    assign contador_giro_out = cont_q;
    assign estado_out        = estado_q;
    assign pedido_ready_out  = (estado_q == ST_IDLE);
    assign concluido_out     = (estado_q == ST_CONCLUIDO);
    assign erro_out          = (estado_q == ST_ERRO);

endmodule

// File: tb/tb_controle_venda.sv
// Directed bench for controle_venda with short timeout and debounce settings.
module tb_controle_venda;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [3:0] giro;
    logic       ready;
    logic       s1, s2, ack;
    logic       rele;
    logic [3:0] cont;
    logic [2:0] estado;
    logic       concl, erro;

    int checks = 0;
    int errors = 0;

    int         n_est = 0;
    logic [2:0] seq_est [64];
    logic [2:0] est_ant = 3'd0;
    int         n_concl = 0;

    always #5 clk = ~clk;

    controle_venda #(
        .TIMEOUT_CYCLES  (200),
        .DEBOUNCE_CYCLES (4),
        .MAX_GIRO        (9)
    ) dut (
        .clock_in          (clk),
        .reset_in          (rst),
        .pedido_valid_in   (valid),
        .pedido_giro_in    (giro),
        .pedido_ready_out  (ready),
        .sensor1_in        (s1),
        .sensor2_in        (s2),
        .ack_erro_in       (ack),
        .rele_out          (rele),
        .contador_giro_out (cont),
        .estado_out        (estado),
        .concluido_out     (concl),
        .erro_out          (erro)
    );

    always @(negedge clk) begin
        if (concl) n_concl <= n_concl + 1;
        if (estado != est_ant) begin
            if (n_est < 64) seq_est[n_est] <= estado;
            n_est <= n_est + 1;
        end
        est_ant <= estado;
    end

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        if (obs !== esp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
        end
    endtask

    task automatic ciclos(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pedido(input logic [3:0] g);
        valid = 1'b1;
        giro  = g;
        ciclos(1);
        valid = 1'b0;
        giro  = 4'd0;
    endtask

    task automatic pulso_s1(input int alto, input int baixo);
        s1 = 1'b1;
        ciclos(alto);
        s1 = 1'b0;
        ciclos(baixo);
    endtask

    task automatic pulso_s2(input int alto, input int baixo);
        s2 = 1'b1;
        ciclos(alto);
        s2 = 1'b0;
        ciclos(baixo);
    endtask

    initial begin
        int n0;
        int c0;
        rst = 1'b1; valid = 1'b0; giro = 4'd0; s1 = 1'b0; s2 = 1'b0; ack = 1'b0;
        ciclos(3);
        rst = 1'b0;
        ciclos(2);

        verifica("rst_ready", ready, 1);
        verifica("rst_rele", rele, 0);
        verifica("rst_estado", estado, 0);
        verifica("rst_cont", cont, 0);
        verifica("rst_concl", concl, 0);
        verifica("rst_erro", erro, 0);

        // normal sale of three turns
        n0 = n_est;
        c0 = n_concl;
        pedido(4'd3);
        verifica("s1_rele_accept", rele, 1);
        verifica("s1_estado_accept", estado, 1);
        verifica("s1_ready_busy", ready, 0);
        pulso_s1(20, 20);
        verifica("s1_cont1", cont, 1);
        pulso_s1(20, 20);
        verifica("s1_cont2", cont, 2);
        verifica("s1_rele_before3", rele, 1);
        pulso_s1(20, 20);
        verifica("s1_cont3", cont, 3);
        verifica("s1_rele_after3", rele, 0);
        verifica("s1_estado_espera", estado, 2);
        pulso_s2(20, 10);
        verifica("s1_estado_idle", estado, 0);
        verifica("s1_cont_hold", cont, 3);
        verifica("s1_concl_once", n_concl - c0, 1);
        verifica("s1_seq_len", n_est - n0, 4);
        verifica("s1_seq0", seq_est[n0], 1);
        verifica("s1_seq1", seq_est[n0+1], 2);
        verifica("s1_seq2", seq_est[n0+2], 3);
        verifica("s1_seq3", seq_est[n0+3], 0);

        // jam: two turns requested, only one arrives
        pedido(4'd2);
        pulso_s1(20, 20);
        verifica("jam_cont1", cont, 1);
        ciclos(150);
        verifica("jam_no_err_yet", erro, 0);
        verifica("jam_rele_still", rele, 1);
        ciclos(30);
        verifica("jam_erro", erro, 1);
        verifica("jam_rele", rele, 0);
        verifica("jam_estado", estado, 4);
        verifica("jam_cont", cont, 1);
        verifica("jam_ready", ready, 0);
        ack = 1'b1; valid = 1'b1; giro = 4'd1;
        ciclos(1);
        valid = 1'b0; giro = 4'd0;
        verifica("ack_estado", estado, 0);
        verifica("ack_ready", ready, 1);
        ciclos(3);
        verifica("ack_req_dropped", estado, 0);
        verifica("ack_idle_noeffect", erro, 0);
        ack = 1'b0;

        // missing drop
        pedido(4'd1);
        pulso_s1(20, 20);
        verifica("nodrop_espera", estado, 2);
        verifica("nodrop_rele", rele, 0);
        ciclos(150);
        verifica("nodrop_no_err_yet", erro, 0);
        ciclos(30);
        verifica("nodrop_erro", erro, 1);
        verifica("nodrop_estado", estado, 4);
        verifica("nodrop_cont", cont, 1);
        ack = 1'b1;
        ciclos(1);
        ack = 1'b0;
        verifica("nodrop_ack", estado, 0);

        // glitches and bounce must not count
        pedido(4'd2);
        repeat (3) pulso_s1(2, 5);
        repeat (4) pulso_s1(3, 1);
        ciclos(6);
        verifica("glitch_cont", cont, 0);
        verifica("glitch_estado", estado, 1);
        pulso_s1(10, 10);
        verifica("clean_cont", cont, 1);
        pedido(4'd5);
        ciclos(2);
        verifica("busy_req_cont", cont, 1);
        verifica("busy_req_estado", estado, 1);
        pulso_s1(10, 10);
        verifica("glitch_cont2", cont, 2);
        verifica("glitch_espera", estado, 2);
        pulso_s2(10, 10);
        verifica("glitch_done", estado, 0);

        // illegal turn counts are ignored
        pedido(4'd0);
        verifica("giro0_estado", estado, 0);
        verifica("giro0_rele", rele, 0);
        pedido(4'd10);
        verifica("giro10_estado", estado, 0);
        verifica("giro10_ready", ready, 1);
        verifica("giro_ilegal_cont", cont, 2);
        pedido(4'd9);
        verifica("giro9_estado", estado, 1);
        verifica("giro9_cont_clr", cont, 0);

        // reset in the middle of a sale
        pulso_s1(20, 20);
        verifica("mid_cont", cont, 1);
        verifica("mid_rele", rele, 1);
        rst = 1'b1;
        #1;
        verifica("rst_async_rele", rele, 0);
        ciclos(2);
        verifica("rstmid_estado", estado, 0);
        verifica("rstmid_cont", cont, 0);
        verifica("rstmid_ready", ready, 1);
        verifica("rstmid_erro", erro, 0);
        rst = 1'b0;
        ciclos(1);
        pedido(4'd1);
        verifica("post_rst_estado", estado, 1);
        verifica("post_rst_rele", rele, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
